// File: rtl/fp_decode_arbiter.sv
// fp_decode_arbiter
//
// Purpose:
//   Shares one external combinational float decoder among NUM_REQ requesters.
//   The requesters are served round-robin. The winner's IEEE-754 word is
//   registered onto the decoder operand ports. One cycle later the decoder
//   result is captured, and the NaN/Inf, overflow and zero overrides are
//   applied. The result is then returned with the requester index over a
//   valid/ready response channel.
//
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   req_valid     - per-requester request valid
//   req_data      - packed float words, requester i in bits [32i+31:32i]
//   req_ready     - one-hot grant, combinational, only ever set in IDLE
//   dec_sign      - registered operand sign to the shared decoder
//   dec_exponent  - registered operand exponent to the shared decoder
//   dec_mantissa  - registered operand mantissa to the shared decoder
//   dec_int_part  - decoder integer result (combinational from dec_*)
//   dec_frac      - decoder fraction result (combinational from dec_*)
//   rsp_valid     - response valid
//   rsp_ready     - response consumer ready
//   rsp_id        - index of the served requester
//   rsp_int       - final integer part
//   rsp_frac      - final fraction
//   rsp_flags     - {nan_inf, overflow, zero}

module fp_decode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    dec_sign,
  output logic [7:0]              dec_exponent,
  output logic [22:0]             dec_mantissa,
  input  logic [15:0]             dec_int_part,
  input  logic [15:0]             dec_frac,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_int,
  output logic [15:0]             rsp_frac,
  output logic [2:0]              rsp_flags
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   search_idx;
  logic              found;
  logic [31:0]       win_word;

  // Rotating priority search. It starts one past the last winner, so the
  // requester that was just served has the lowest priority.
  always_comb begin
    grant      = '0;
    found      = 1'b0;
    search_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      search_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[search_idx]) begin
        grant[search_idx] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  // The grant is one-hot, so selecting the operand word is a plain mux on it.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_word = req_data[32*i +: 32];
      end
    end
  end

  // The grant is gated by rst_n. This keeps req_ready low while reset is held,
  // even though the state already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n) begin
      req_ready = grant;
    end
  end

  // Transaction FSM. The operands stay registered between transactions, so
  // the decoder inputs do not toggle while the block is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= ID_W'(NUM_REQ - 1);
      dec_sign     <= 1'b0;
      dec_exponent <= '0;
      dec_mantissa <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_int      <= '0;
      rsp_frac     <= '0;
      rsp_flags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            dec_sign     <= win_word[31];
            dec_exponent <= win_word[30:23];
            dec_mantissa <= win_word[22:0];
            for (int i = 0; i < NUM_REQ; i++) begin
              if (grant[i]) begin
                rsp_id <= ID_W'(i);
                ptr    <= ID_W'(i);
              end
            end
            state <= EVAL;
          end
        end

        EVAL: begin
          // The checks are in priority order. Exponents of 142 and above have
          // an unbiased value of 15 or more, which does not fit a signed
          // 16-bit integer, so the result saturates like Inf.
          if (dec_exponent == 8'hFF) begin
            rsp_flags <= 3'b100;
            rsp_int   <= dec_sign ? 16'h8000 : 16'h7FFF;
            rsp_frac  <= '0;
          end else if (dec_exponent >= 8'd142) begin
            rsp_flags <= 3'b010;
            rsp_int   <= dec_sign ? 16'h8000 : 16'h7FFF;
            rsp_frac  <= '0;
          end else if (dec_exponent == 8'h00) begin
            rsp_flags <= 3'b001;
            rsp_int   <= '0;
            rsp_frac  <= '0;
          end else begin
            rsp_flags <= 3'b000;
            rsp_int   <= dec_int_part;
            rsp_frac  <= dec_frac;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_decode_arbiter.sv
// Testbench for fp_decode_arbiter, with NUM_REQ = 4.
// The decoder is stubbed. The stub returns either fixed values or a simple
// hash of the operand fields. The reference model computes every expected
// response from the raw request words and the round-robin rule.

module tb_fp_decode_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [31:0]   words [N];
  logic [32*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          dec_sign;
  logic [7:0]    dec_exponent;
  logic [22:0]   dec_mantissa;
  logic [15:0]   dec_int_part;
  logic [15:0]   dec_frac;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_int;
  logic [15:0]   rsp_frac;
  logic [2:0]    rsp_flags;

  logic          stub_fixed;
  logic [15:0]   stub_int;
  logic [15:0]   stub_frac;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last;

  always #5 clk = ~clk;

  assign req_data = {words[3], words[2], words[1], words[0]};

  // Decoder stub. It is combinational from the dec_* operands.
  assign dec_int_part = stub_fixed ? stub_int  : {dec_sign, dec_exponent[6:0], dec_mantissa[7:0]};
  assign dec_frac     = stub_fixed ? stub_frac : dec_mantissa[22:7];

  fp_decode_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .dec_sign     (dec_sign),
    .dec_exponent (dec_exponent),
    .dec_mantissa (dec_mantissa),
    .dec_int_part (dec_int_part),
    .dec_frac     (dec_frac),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_int      (rsp_int),
    .rsp_frac     (rsp_frac),
    .rsp_flags    (rsp_flags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
  endtask

  // The next winner is the first valid requester after the last one served,
  // wrapping around.
  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (model_last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Expected response for one request word.
  function automatic void model_result(input logic [31:0] w, output logic [15:0] ei,
                                       output logic [15:0] ef, output logic [2:0] fl);
    int e;
    e = int'(w[30:23]);
    if (e == 255) begin
      fl = 3'b100; ei = w[31] ? 16'h8000 : 16'h7FFF; ef = 16'h0000;
    end else if (e - 127 >= 15) begin
      fl = 3'b010; ei = w[31] ? 16'h8000 : 16'h7FFF; ef = 16'h0000;
    end else if (e == 0) begin
      fl = 3'b001; ei = 16'h0000; ef = 16'h0000;
    end else begin
      fl = 3'b000;
      ei = stub_fixed ? stub_int  : {w[31], w[29:23], w[7:0]};
      ef = stub_fixed ? stub_frac : w[22:7];
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0:       e = 8'hFF;
      1:       e = 8'h00;
      2:       e = 8'($urandom_range(142, 254));
      default: e = 8'($urandom_range(1, 141));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // One complete transaction. It starts in IDLE with the inputs already applied.
  // delay is the number of RESP cycles during which rsp_ready is held low.
  task automatic serveOne(input string tag, input int delay, output int served);
    int w;
    logic [31:0] word;
    logic [15:0] ei, ef;
    logic [2:0]  fl;
    w = model_winner(req_valid);
    if (w < 0) w = 0;
    served = w;
    #1;
    checkOutput($sformatf("%s.grant", tag), 32'(req_ready), 32'(1) << w);
    word = words[w];
    model_result(word, ei, ef, fl);
    @(posedge clk); #1;
    checkOutput($sformatf("%s.dec_sign", tag), 32'(dec_sign), 32'(word[31]));
    checkOutput($sformatf("%s.dec_exp", tag), 32'(dec_exponent), 32'(word[30:23]));
    checkOutput($sformatf("%s.dec_mant", tag), 32'(dec_mantissa), 32'(word[22:0]));
    checkOutput($sformatf("%s.eval_valid", tag), 32'(rsp_valid), 32'(0));
    checkOutput($sformatf("%s.eval_ready", tag), 32'(req_ready), 32'(0));
    rsp_ready = (delay == 0);
    @(posedge clk); #1;
    checkOutput($sformatf("%s.rsp_valid", tag), 32'(rsp_valid), 32'(1));
    checkOutput($sformatf("%s.rsp_id", tag), 32'(rsp_id), 32'(w));
    checkOutput($sformatf("%s.rsp_int", tag), 32'(rsp_int), 32'(ei));
    checkOutput($sformatf("%s.rsp_frac", tag), 32'(rsp_frac), 32'(ef));
    checkOutput($sformatf("%s.rsp_flags", tag), 32'(rsp_flags), 32'(fl));
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s.hold_valid", tag), 32'(rsp_valid), 32'(1));
      checkOutput($sformatf("%s.hold_id", tag), 32'(rsp_id), 32'(w));
      checkOutput($sformatf("%s.hold_int", tag), 32'(rsp_int), 32'(ei));
      checkOutput($sformatf("%s.hold_flags", tag), 32'(rsp_flags), 32'(fl));
      checkOutput($sformatf("%s.hold_ready", tag), 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput($sformatf("%s.done_valid", tag), 32'(rsp_valid), 32'(0));
    model_last = w;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int w;
    rst_n      = 1'b0;
    stub_fixed = 1'b1;
    stub_int   = 16'h0001;
    stub_frac  = 16'h0000;
    for (int i = 0; i < N; i++) words[i] = 32'h3F80_0000;
    applyStimulus(4'b1111, 1'b1);
    model_last = N - 1;

    // Reset values, with every requester valid so the grant gating is exercised.
    #12;
    checkOutput("reset.req_ready", 32'(req_ready), 32'(0));
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset.rsp_id", 32'(rsp_id), 32'(0));
    checkOutput("reset.rsp_int", 32'(rsp_int), 32'(0));
    checkOutput("reset.rsp_flags", 32'(rsp_flags), 32'(0));
    checkOutput("reset.dec_exp", 32'(dec_exponent), 32'(0));
    rst_n = 1'b1;

    // All four requesters active. The expected grant order is 0,1,2,3,0.
    $display("[TB] round-robin with all requesters active");
    for (int t = 0; t < 5; t++) serveOne("rr", 0, s);

    // Single request from requester 2 with a known operand.
    $display("[TB] single request from requester 2");
    stub_int  = 16'h1234;
    stub_frac = 16'h0567;
    words[2]  = 32'h40A0_0000;
    applyStimulus(4'b0100, 1'b1);
    serveOne("single", 0, s);
    checkOutput("single.exp_const", 32'(dec_exponent), 32'h81);
    checkOutput("single.mant_const", 32'(dec_mantissa), 32'h20_0000);
    applyStimulus(4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle.req_ready", 32'(req_ready), 32'(0));
    checkOutput("idle.rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("idle.dec_exp_hold", 32'(dec_exponent), 32'h81);

    // Special operands: +Inf, -Inf, 65536.0 and a denormal.
    $display("[TB] override words");
    stub_int  = 16'hAAAA;
    stub_frac = 16'h5555;
    words[0] = 32'h7F80_0000;
    words[1] = 32'hFF80_0000;
    words[2] = 32'h4780_0000;
    words[3] = 32'h0000_0001;
    applyStimulus(4'b1111, 1'b1);
    for (int t = 0; t < 4; t++) serveOne("ovr", 0, s);

    // Backpressure while another requester keeps waiting.
    $display("[TB] backpressure");
    words[0] = 32'h3FC0_0000;
    words[1] = 32'h4120_0000;
    applyStimulus(4'b0011, 1'b1);
    serveOne("bp", 5, s);
    applyStimulus(req_valid & ~(4'(1) << s), 1'b1);
    serveOne("bp_next", 0, s);

    // Reset asserted while a response is pending.
    $display("[TB] reset during RESP");
    applyStimulus(4'b1111, 1'b0);
    w = model_winner(req_valid);
    #1;
    checkOutput("rst.grant", 32'(req_ready), 32'(1) << w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst.pre_valid", 32'(rsp_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst.rsp_int", 32'(rsp_int), 32'(0));
    checkOutput("rst.rsp_id", 32'(rsp_id), 32'(0));
    checkOutput("rst.dec_exp", 32'(dec_exponent), 32'(0));
    checkOutput("rst.req_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_last = N - 1;
    #1;
    checkOutput("rst.no_rsp", 32'(rsp_valid), 32'(0));
    checkOutput("rst.first_grant", 32'(req_ready), 32'b0001);
    applyStimulus(4'b1111, 1'b1);
    serveOne("post_rst", 0, s);

    // Randomized traffic checked against the model.
    $display("[TB] randomized traffic");
    stub_fixed = 1'b0;
    for (int i = 0; i < N; i++) words[i] = rand_word();
    for (int t = 0; t < 40; t++) begin
      serveOne("rnd", int'($urandom_range(0, 3)), s);
      req_valid[s] = 1'($urandom_range(0, 1));
      words[s]     = rand_word();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          words[i]     = rand_word();
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        req_valid[$urandom_range(0, N - 1)] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
